bf_mem_bridge: RTL
==================

Name: bf_mem_bridge

Overview:
Memory/I-O bridge directly downstream of the BF processor core's external pin bus (write, addr, instr_addr, 8-bit shared data bus). Decodes bus phases, latches addresses, and routes them to three targets: a program memory port (instruction space), a data RAM port (data space), and a memory-mapped console (input/output byte FIFOs with valid/ready handshakes). Drives read data back onto the processor's data-in bus.

Parameters:
IO_ADDR, 8'hFF, data-space address mapped to the console instead of data RAM
FIFO_DEPTH, 4, entries in each console FIFO (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_write  in  1  processor write pin (1 = processor drives bus)
cpu_addr  in  1  processor addr pin (1 = address phase)
cpu_instr_addr  in  1  address targets program space when 1
cpu_bus_out  in  8  bus value driven by processor (address or write data)
cpu_bus_in  out  8  read data returned to processor
prog_addr  out  8  program memory address
prog_rd_en  out  1  program memory read strobe
prog_rdata  in  8  program memory data, valid 1 cycle after prog_rd_en
ram_addr  out  8  data RAM address
ram_rd_en  out  1  data RAM read strobe
ram_we  out  1  data RAM write strobe
ram_wdata  out  8  data RAM write data
ram_rdata  in  8  data RAM data, valid 1 cycle after ram_rd_en
in_valid  in  1  console input byte offered
in_data  in  8  console input byte
in_ready  out  1  input FIFO not full
out_valid  out  1  output FIFO not empty
out_data  out  8  output FIFO head byte
out_ready  in  1  consumer accepts out_data
overflow  out  1  sticky: console write dropped (output FIFO full)

Behaviour:
- Reset (async, rst_n=0): addr_q=0, space_q=0, hold_q=0, pending=0, both FIFOs empty, overflow=0; all strobes 0, cpu_bus_in=0, out_valid=0, in_ready=1.
- Phase decode per cycle: ADDR = cpu_addr&cpu_write; WRITE = ~cpu_addr&cpu_write; READ = ~cpu_addr&~cpu_write; cpu_addr&~cpu_write = IDLE (no action).
- ADDR cycle: addr_q<=cpu_bus_out, space_q<=cpu_instr_addr. Same cycle, combinationally: program space -> prog_rd_en=1, prog_addr=cpu_bus_out; data space, address!=IO_ADDR -> ram_rd_en=1, ram_addr=cpu_bus_out; data space, address==IO_ADDR -> pop input FIFO if non-empty, hold_q<=head, else hold_q<=8'h00 (no pop). pending<=1 for memory targets.
- Cycle after ADDR with pending=1: cpu_bus_in = selected rdata (combinational); hold_q<=that rdata; pending<=0. Otherwise cpu_bus_in=hold_q. Read data therefore valid from the cycle after ADDR until the next ADDR.
- WRITE cycle: data space, addr_q!=IO_ADDR -> ram_we=1, ram_addr=addr_q, ram_wdata=cpu_bus_out. addr_q==IO_ADDR -> push cpu_bus_out to output FIFO; if full, drop and overflow<=1 (sticky until reset). Program space -> ignored, no strobe.
- Input FIFO: push when in_valid&in_ready. Output FIFO: pop when out_valid&out_ready. Simultaneous push+pop on a full FIFO: pop and push both occur, count unchanged. Simultaneous push+pop on an empty FIFO: push only, no bypass.
- Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Back-to-back ADDR cycles: the latest one wins; the earlier pending read is discarded.
- Reset mid-transaction: pending read is abandoned, FIFO contents are lost.

Optional Feature:
BF_BRIDGE_FETCH_CNT_EN: when defined, adds output port fetch_count[15:0], incremented on each program-space ADDR cycle. It saturates at 16'hFFFF and resets to 0. When undefined, the port and counter are absent.

Decomposition:
- Package bf_bus_pkg: phase enum (IDLE, ADDR, WRITE, READ), BUS_W=8, default IO_ADDR constant.
- Sub-module bf_fifo (parameter DEPTH, WIDTH; push/pop/full/empty/head). Instantiate it twice, once for console input and once for console output.

Test Plan:
- Program fetch: ADDR with instr_addr=1 and bus=8'h10, then READ; prog_rdata=8'h2B -> prog_rd_en=1 with prog_addr=8'h10 in the ADDR cycle; cpu_bus_in=8'h2B the next cycle and held.
- RAM write/read: ADDR data 8'h05, WRITE 8'hA7 -> ram_we=1, ram_addr=8'h05, ram_wdata=8'hA7; a later ADDR 8'h05 -> ram_rd_en=1, and returned 8'hA7 appears on cpu_bus_in.
- Console out: 5 writes to 8'hFF (bytes 1..5) with out_ready=0 -> out_valid=1, out_data=1, overflow=1 after the 5th; drain with out_ready=1 -> 1,2,3,4 then out_valid=0.
- Console in: push 8'h41 via in_valid; ADDR 8'hFF (data) -> cpu_bus_in=8'h41 next cycle; a second read with the FIFO empty -> 8'h00.
- Program-space write: ADDR instr 8'h03, WRITE 8'hFF -> no ram_we and no FIFO push.
- Async reset asserted mid-read (cycle after ADDR) -> cpu_bus_in=0 and FIFOs empty immediately; with the optional feature defined, fetch_count=0.

Source files
------------

// File: rtl/bf_bus_pkg.sv
// Shared bus definitions for the BF core pin-bus bridge: phase encoding, bus width and
// the default console address.
package bf_bus_pkg;

  localparam int unsigned BUS_W = 8;
  localparam logic [BUS_W-1:0] DEFAULT_IO_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    PhIdle,
    PhAddr,
    PhWrite,
    PhRead
  } bus_phase_e;

  // The core encodes its bus phase on the write/addr pin pair.
  function automatic bus_phase_e decode_phase(input logic write, input logic addr);
    bus_phase_e ph;
    if (write && addr) begin
      ph = PhAddr;
    end else if (write) begin
      ph = PhWrite;
    end else if (!addr) begin
      ph = PhRead;
    end else begin
      ph = PhIdle;
    end
    return ph;
  endfunction

endpackage

// File: rtl/bf_fifo.sv
// Synchronous FIFO for the console byte streams. On a full FIFO a push is accepted only
// alongside a pop; on an empty FIFO a pop is ignored (no bypass).
module bf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bf_mem_bridge.sv
// Bridge from the BF core pin bus to program memory, data RAM and a memory-mapped console.
// Define BF_BRIDGE_FETCH_CNT_EN to add the saturating fetch_count output.
module bf_mem_bridge
  import bf_bus_pkg::*;
#(
  parameter logic [BUS_W-1:0] IO_ADDR    = DEFAULT_IO_ADDR,
  parameter int unsigned      FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_write,
  input  logic             cpu_addr,
  input  logic             cpu_instr_addr,
  input  logic [BUS_W-1:0] cpu_bus_out,
  output logic [BUS_W-1:0] cpu_bus_in,
  output logic [BUS_W-1:0] prog_addr,
  output logic             prog_rd_en,
  input  logic [BUS_W-1:0] prog_rdata,
  output logic [BUS_W-1:0] ram_addr,
  output logic             ram_rd_en,
  output logic             ram_we,
  output logic [BUS_W-1:0] ram_wdata,
  input  logic [BUS_W-1:0] ram_rdata,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_data,
  input  logic             out_ready,
  output logic             overflow
`ifdef BF_BRIDGE_FETCH_CNT_EN
  ,
  output logic [15:0]      fetch_count
`endif
);

  bus_phase_e       phase;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic             space_q, space_d;
  logic [BUS_W-1:0] hold_q, hold_d;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [BUS_W-1:0] rdata_sel;

  logic             in_full, in_empty, in_push, in_pop;
  logic [BUS_W-1:0] in_head;
  logic             out_full, out_empty, out_push, out_pop;

  assign phase     = decode_phase(cpu_write, cpu_addr);
  assign rdata_sel = space_q ? prog_rdata : ram_rdata;

  assign in_ready  = !in_full;
  assign in_push   = in_valid && in_ready;
  assign out_valid = !out_empty;
  assign out_pop   = out_valid && out_ready;
  assign overflow  = overflow_q;
  assign ram_wdata = cpu_bus_out;

  always_comb begin
    addr_d     = addr_q;
    space_d    = space_q;
    overflow_d = overflow_q;
    prog_rd_en = 1'b0;
    prog_addr  = addr_q;
    ram_rd_en  = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    pending_d  = 1'b0;
    // Memory data arrives one cycle after the strobe; present it and keep a copy.
    cpu_bus_in = pending_q ? rdata_sel : hold_q;
    hold_d     = pending_q ? rdata_sel : hold_q;

    unique case (phase)
      PhAddr: begin
        addr_d  = cpu_bus_out;
        space_d = cpu_instr_addr;
        if (cpu_instr_addr) begin
          prog_rd_en = 1'b1;
          prog_addr  = cpu_bus_out;
          pending_d  = 1'b1;
          hold_d     = hold_q;
        end else if (cpu_bus_out != IO_ADDR) begin
          ram_rd_en = 1'b1;
          ram_addr  = cpu_bus_out;
          pending_d = 1'b1;
          hold_d    = hold_q;
        end else begin
          in_pop = !in_empty;
          hold_d = in_empty ? '0 : in_head;
        end
      end
      PhWrite: begin
        if (!space_q) begin
          if (addr_q != IO_ADDR) begin
            ram_we = 1'b1;
          end else begin
            out_push = 1'b1;
            // A full FIFO still takes the byte if the consumer drains one this cycle.
            if (out_full && !out_pop) begin
              overflow_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      space_q    <= 1'b0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      space_q    <= space_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  bf_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUS_W)
  ) u_in_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (in_push),
    .data_i  (in_data),
    .pop_i   (in_pop),
    .full_o  (in_full),
    .empty_o (in_empty),
    .head_o  (in_head)
  );

  bf_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUS_W)
  ) u_out_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (out_push),
    .data_i  (cpu_bus_out),
    .pop_i   (out_pop),
    .full_o  (out_full),
    .empty_o (out_empty),
    .head_o  (out_data)
  );

`ifdef BF_BRIDGE_FETCH_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (phase == PhAddr && cpu_instr_addr && fetch_cnt_q != 16'hFFFF) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
`endif

endmodule
